level_select: RTL and testbench

- Produces the 3-bit level code that the HEX0 level display consumes. It is the writer side of the level interface.
- The player steps the level up or down with two push buttons while in menu mode.
- During play, the game logic advances the level with a one-cycle level_clear pulse.
- Outputs feed the level display and the cart game core. Everything is registered in one clock domain.

---
 rtl/level_pkg.sv | 19 +
 rtl/level_select_button_press.sv | 103 ++++++++++
 rtl/level_select.sv | 103 ++++++++++
 tb/tb_level_select.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared types for the level-select slice: level code width and the
// per-button press FSM states.
package level_pkg;

  localparam int LEVEL_W = 3;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/level_select_button_press.sv
// Push-button conditioner: 2-flop synchronizer plus a press/hold/auto-repeat
// FSM emitting a one-cycle step pulse.
module button_press
  import level_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [1:0]       valid_q, valid_d;
  logic             armed_q, armed_d;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state, counter and step pulse. armed_q only rises once the
  // synchronizer holds genuine post-reset samples and shows a released
  // button, so a key held through reset never fires.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    valid_d = {valid_q[0], 1'b1};
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;

    if (valid_q[1] && !sync2_q) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      IDLE: begin
        if (sync2_q && armed_q) begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = DELAY;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (!sync2_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!sync2_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      valid_q <= 2'b00;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/level_select.sv
// Level register for the HEX0 level display: button stepping in menu mode,
// level_clear advance in play mode, sticky game_done.
module level_select
  import level_pkg::*;
#(
  parameter int START_LEVEL   = 0,
  parameter int MAX_LEVEL     = 7,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_btn,
  input  logic               down_btn,
  input  logic               menu_mode,
  input  logic               level_clear,
  output logic [LEVEL_W-1:0] level,
  output logic               level_changed,
  output logic               game_done
);

  localparam level_t START_L   = level_t'(START_LEVEL);
  localparam level_t MAX_L     = level_t'(MAX_LEVEL);
  localparam level_t LEVEL_ONE = level_t'(1);

  logic   up_step;
  logic   down_step;
  level_t level_q, level_d;
  logic   level_changed_q, level_changed_d;
  logic   game_done_q, game_done_d;

  button_press #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .btn  (up_btn),
    .step (up_step)
  );

  button_press #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_down (
    .clk  (clk),
    .reset(reset),
    .btn  (down_btn),
    .step (down_step)
  );

  // Next level and game_done; level_changed flags a real value change only.
  always_comb begin
    level_d     = level_q;
    game_done_d = game_done_q;
    if (menu_mode) begin
      if (up_step && !down_step) begin
        if (level_q < MAX_L) begin
          level_d = level_q + LEVEL_ONE;
        end else begin
          level_d = level_q;
        end
      end else if (down_step && !up_step) begin
        if (level_q != '0) begin
          level_d = level_q - LEVEL_ONE;
        end else begin
          level_d = level_q;
        end
      end else begin
        level_d = level_q;
      end
    end else begin
      if (level_clear && !game_done_q) begin
        if (level_q < MAX_L) begin
          level_d = level_q + LEVEL_ONE;
        end else begin
          game_done_d = 1'b1;
        end
      end else begin
        level_d = level_q;
      end
    end
    level_changed_d = (level_d != level_q);
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q         <= START_L;
      level_changed_q <= 1'b0;
      game_done_q     <= 1'b0;
    end else begin
      level_q         <= level_d;
      level_changed_q <= level_changed_d;
      game_done_q     <= game_done_d;
    end
  end

  assign level         = level_q;
  assign level_changed = level_changed_q;
  assign game_done     = game_done_q;

endmodule

// File: tb/tb_level_select.sv
// Self-checking bench for level_select: a cycle-level behavioural model
// compared every cycle, plus directed vectors with literal expectations.
module tb_level_select;

  localparam int HOLD  = 4;
  localparam int REP   = 2;
  localparam int START = 0;
  localparam int MAXL  = 7;

  logic       clk;
  logic       reset;
  logic       up_btn;
  logic       down_btn;
  logic       menu_mode;
  logic       level_clear;
  logic [2:0] level;
  logic       level_changed;
  logic       game_done;

  int errors = 0;
  int checks = 0;

  level_select #(
    .START_LEVEL  (START),
    .MAX_LEVEL    (MAXL),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .up_btn       (up_btn),
    .down_btn     (down_btn),
    .menu_mode    (menu_mode),
    .level_clear  (level_clear),
    .level        (level),
    .level_changed(level_changed),
    .game_done    (game_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each button's synchronized value is the raw value
  // from two edges earlier; a press of run length k steps at k==0 and at
  // k = HOLD + n*REP. Arming requires a genuine released sample after reset.
  bit m_valid = 1'b0;
  int m_level;
  bit m_done;
  bit m_changed;
  bit s1 [2];
  bit s2 [2];
  bit v1 [2];
  bit v2 [2];
  bit armed [2];
  int run [2];
  bit raw [2];
  bit stp [2];
  int nl;

  always @(posedge clk) begin
    raw[0] = up_btn;
    raw[1] = down_btn;
    if (!reset) begin
      m_valid   = 1'b1;
      m_level   = START;
      m_done    = 1'b0;
      m_changed = 1'b0;
      for (int i = 0; i < 2; i++) begin
        s1[i] = 1'b0; s2[i] = 1'b0; v1[i] = 1'b0; v2[i] = 1'b0;
        armed[i] = 1'b0; run[i] = 0;
      end
    end else if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        stp[i] = s2[i] && armed[i] &&
                 (run[i] == 0 || (run[i] >= HOLD && ((run[i] - HOLD) % REP) == 0));
        if (s2[i] && armed[i]) run[i] = run[i] + 1;
        else run[i] = 0;
        if (v2[i] && !s2[i]) armed[i] = 1'b1;
        s2[i] = s1[i]; v2[i] = v1[i];
        s1[i] = raw[i]; v1[i] = 1'b1;
      end
      nl = m_level;
      if (menu_mode) begin
        if (stp[0] && !stp[1]) nl = (m_level < MAXL) ? m_level + 1 : m_level;
        else if (stp[1] && !stp[0]) nl = (m_level > 0) ? m_level - 1 : m_level;
      end else if (level_clear && !m_done) begin
        if (m_level < MAXL) nl = m_level + 1;
        else m_done = 1'b1;
      end
      m_changed = (nl != m_level);
      m_level   = nl;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_level", {29'd0, level}, m_level);
      chk("model_changed", {31'd0, level_changed}, {31'd0, m_changed});
      chk("model_done", {31'd0, game_done}, {31'd0, m_done});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input logic u, input logic d);
    up_btn   = u;
    down_btn = d;
    @(negedge clk);
    up_btn   = 1'b0;
    down_btn = 1'b0;
    wait_cycles(6);
  endtask

  int pulses;

  initial begin
    reset       = 1'b0;
    up_btn      = 1'b0;
    down_btn    = 1'b0;
    menu_mode   = 1'b1;
    level_clear = 1'b0;

    // Reset then idle
    wait_cycles(2);
    reset = 1'b1;
    chk("reset_level", {29'd0, level}, 32'd0);
    chk("reset_changed", {31'd0, level_changed}, 32'd0);
    chk("reset_done", {31'd0, game_done}, 32'd0);
    wait_cycles(20);
    chk("idle_level", {29'd0, level}, 32'd0);

    // Single press: level moves exactly two edges after the sampling edge
    up_btn = 1'b1;
    @(negedge clk);
    up_btn = 1'b0;
    chk("lat_edge0", {29'd0, level}, 32'd0);
    @(negedge clk);
    chk("lat_edge1", {29'd0, level}, 32'd0);
    @(negedge clk);
    chk("lat_edge2_level", {29'd0, level}, 32'd1);
    chk("lat_edge2_changed", {31'd0, level_changed}, 32'd1);
    @(negedge clk);
    chk("lat_pulse_end", {31'd0, level_changed}, 32'd0);
    wait_cycles(4);
    tap(1'b0, 1'b1);
    chk("down_tap", {29'd0, level}, 32'd0);
    tap(1'b0, 1'b1);
    chk("down_sat", {29'd0, level}, 32'd0);

    // Hold repeat: 12 synced-high cycles give steps at 0,4,6,8,10
    up_btn = 1'b1;
    wait_cycles(12);
    up_btn = 1'b0;
    wait_cycles(6);
    chk("hold_level", {29'd0, level}, 32'd5);
    wait_cycles(10);
    chk("release_level", {29'd0, level}, 32'd5);

    // Simultaneous press: no change
    tap(1'b1, 1'b1);
    chk("both_level", {29'd0, level}, 32'd5);

    // Saturation at MAX_LEVEL
    tap(1'b1, 1'b0);
    chk("to_six", {29'd0, level}, 32'd6);
    pulses = 0;
    up_btn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 9) up_btn = 1'b0;
      if (level_changed === 1'b1) pulses++;
    end
    chk("sat_level", {29'd0, level}, 32'd7);
    chk("sat_pulses", pulses, 32'd1);

    // Play mode
    tap(1'b0, 1'b1);
    tap(1'b0, 1'b1);
    chk("back_to_five", {29'd0, level}, 32'd5);
    menu_mode = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < 4; i++) begin
      level_clear = 1'b1;
      @(negedge clk);
      level_clear = 1'b0;
      if (i == 0) chk("clear1_level", {29'd0, level}, 32'd6);
      if (i == 1) chk("clear2_level", {29'd0, level}, 32'd7);
      if (i == 2) chk("clear3_done", {31'd0, game_done}, 32'd1);
      wait_cycles(2);
    end
    chk("done_level", {29'd0, level}, 32'd7);
    tap(1'b1, 1'b0);
    tap(1'b0, 1'b1);
    chk("play_btn_ignored", {29'd0, level}, 32'd7);
    menu_mode = 1'b1;
    wait_cycles(2);
    chk("done_sticky", {31'd0, game_done}, 32'd1);
    tap(1'b0, 1'b1);
    chk("btn_after_done", {29'd0, level}, 32'd6);
    chk("done_still", {31'd0, game_done}, 32'd1);

    // Reset while held in REPEAT
    up_btn = 1'b1;
    wait_cycles(10);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midreset_level", {29'd0, level}, 32'd0);
    chk("midreset_done", {31'd0, game_done}, 32'd0);
    wait_cycles(10);
    chk("held_after_reset", {29'd0, level}, 32'd0);
    up_btn = 1'b0;
    wait_cycles(4);
    chk("released_level", {29'd0, level}, 32'd0);
    tap(1'b1, 1'b0);
    chk("rearmed_level", {29'd0, level}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
